// File: rtl/regfile_mp_pkg.sv
// -----------------------------------------------------------------------------
// regfile_mp_pkg
// Shared types and default sizing for the multi-ported register file.
//   rf_state_e    : clear-sequencer state (RF_IDLE, RF_CLEAR)
//   RF_WIDTH_DEF  : default data word width
//   RF_DEPTH_DEF  : default number of registers
// -----------------------------------------------------------------------------
package regfile_mp_pkg;

   typedef enum logic {
      RF_IDLE  = 1'b0,
      RF_CLEAR = 1'b1
   } rf_state_e;

   localparam int RF_WIDTH_DEF = 16;
   localparam int RF_DEPTH_DEF = 8;

endpackage : regfile_mp_pkg

// File: rtl/regfile_rdport.sv
// -----------------------------------------------------------------------------
// regfile_rdport
// One registered read port: captures the selected word when enabled and
// raises a one-cycle valid strobe. Data holds its last value when idle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_en       : capture enable (read request accepted this cycle)
//   i_data     : already-muxed read word
//   o_data     : registered read data
//   o_valid    : high for the single cycle following an accepted read
// -----------------------------------------------------------------------------
module regfile_rdport #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid
);

   logic [WIDTH-1:0] r_data;
   logic             r_valid;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= i_en;
         if (i_en) begin
            r_data <= i_data;
         end
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;

endmodule : regfile_rdport

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised register file with one synchronous write port, two independent
// registered read ports (A, B) and a run-time clear sweep that zeroes one
// entry per cycle while busy is high.
//
// Configuration macro: REGFILE_BYPASS_EN
//   defined   : write-first; a read colliding with a same-cycle write returns
//               the incoming data_in.
//   undefined : read-first; a colliding read returns the pre-write contents.
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   data_in, writenum, write: write port
//   readnum_a, rd_en_a      : port A request
//   data_out_a, valid_a     : port A registered data and one-cycle valid
//   readnum_b, rd_en_b      : port B request
//   data_out_b, valid_b     : port B registered data and one-cycle valid
//   clr                     : start clear sweep (sampled only when idle)
//   busy                    : clear sweep in progress (DEPTH cycles)
// -----------------------------------------------------------------------------
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH_DEF,
   parameter int DEPTH = RF_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         data_in,
   input  logic [$clog2(DEPTH)-1:0] writenum,
   input  logic                     write,
   input  logic [$clog2(DEPTH)-1:0] readnum_a,
   input  logic                     rd_en_a,
   output logic [WIDTH-1:0]         data_out_a,
   output logic                     valid_a,
   input  logic [$clog2(DEPTH)-1:0] readnum_b,
   input  logic                     rd_en_b,
   output logic [WIDTH-1:0]         data_out_b,
   output logic                     valid_b,
   input  logic                     clr,
   output logic                     busy
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   rf_state_e        r_state;
   logic [AW-1:0]    r_cnt;
   logic             r_busy;

   logic             w_idle;
   logic             w_wr;
   logic             w_rd_a;
   logic             w_rd_b;
   logic [WIDTH-1:0] w_mux_a;
   logic [WIDTH-1:0] w_mux_b;

   assign w_idle = (r_state == RF_IDLE);
   // clr wins over a simultaneous write; reads in the same cycle still go out.
   assign w_wr   = w_idle & write & ~clr;
   assign w_rd_a = w_idle & rd_en_a;
   assign w_rd_b = w_idle & rd_en_b;

`ifdef REGFILE_BYPASS_EN
   // Write-first: forward data_in only for a write that will actually land.
   assign w_mux_a = (w_wr && (readnum_a == writenum)) ? data_in : r_mem[readnum_a];
   assign w_mux_b = (w_wr && (readnum_b == writenum)) ? data_in : r_mem[readnum_b];
`else
   // Read-first: the array read sees the pre-edge contents.
   assign w_mux_a = r_mem[readnum_a];
   assign w_mux_b = r_mem[readnum_b];
`endif

   // Clear sequencer. busy is a flop set on entry so it rises the cycle after
   // clr is sampled and stays high for exactly DEPTH cycles (counter 0..DEPTH-1).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RF_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            RF_IDLE: begin
               if (clr) begin
                  r_state <= RF_CLEAR;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            RF_CLEAR: begin
               if (r_cnt == LAST_IDX) begin
                  r_state <= RF_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + AW'(1);
               end
            end
            default: begin
               r_state <= RF_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: the array is reset explicitly because the datapath relies on every
   // register reading zero after reset; this forces flops rather than a RAM macro.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (r_state == RF_CLEAR) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr) begin
         r_mem[writenum] <= data_in;
      end
   end

   regfile_rdport #(.WIDTH(WIDTH)) u_rdport_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_rd_a),
      .i_data  (w_mux_a),
      .o_data  (data_out_a),
      .o_valid (valid_a)
   );

   regfile_rdport #(.WIDTH(WIDTH)) u_rdport_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_rd_b),
      .i_data  (w_mux_b),
      .o_data  (data_out_b),
      .o_valid (valid_b)
   );

   assign busy = r_busy;

endmodule : regfile_mp

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised, multi-ported successor to the 8x16 datapath register file.
- Configurable WIDTH and DEPTH; one synchronous write port and two independent registered read ports (A, B), each with a valid strobe.
- Run-time clear sequencer zeroes the array one entry per cycle and reports busy.
- Sits between the instruction decoder/controller FSM and the ALU operand latches.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- DEPTH, 8, number of registers (>=2, power of two).
- AW, $clog2(DEPTH), register index width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  WIDTH  write data.
- writenum  in  AW  write index.
- write  in  1  write enable.
- readnum_a  in  AW  port A read index.
- rd_en_a  in  1  port A read request.
- data_out_a  out  WIDTH  port A read data.
- valid_a  out  1  port A data valid, one-cycle pulse.
- readnum_b  in  AW  port B read index.
- rd_en_b  in  1  port B read request.
- data_out_b  out  WIDTH  port B read data.
- valid_b  out  1  port B data valid, one-cycle pulse.
- clr  in  1  start clear sweep, sampled in IDLE only.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset (rst_n=0, async):
  - All DEPTH registers = 0.
  - data_out_a/b = 0, valid_a/b = 0, busy = 0.
  - FSM = IDLE, sweep counter = 0.
- Write: in IDLE with write=1 and clr=0, reg[writenum] <= data_in at the posedge. Write data is visible to reads sampled on the following cycle.
- Read, per port x:
  - In IDLE with rd_en_x=1, data_out_x <= reg[readnum_x] at the posedge and valid_x=1 for exactly that next cycle. Latency is 1 cycle.
  - With rd_en_x=0, valid_x=0 and data_out_x holds its last value.
  - Both ports may read the same index in the same cycle; both return identical data.
- Same-cycle read/write collision (rd_en_x=1, write=1, readnum_x==writenum): governed by REGFILE_BYPASS_EN (see Optional Feature).
- FSM states IDLE, CLEAR:
  - IDLE -> CLEAR when clr=1. Counter <= 0. clr has priority; a simultaneous write is dropped. Simultaneous reads are still served.
  - In CLEAR, each cycle: reg[counter] <= 0, counter++. When counter==DEPTH-1, return to IDLE.
  - busy=1 for exactly DEPTH cycles, registered, starting the cycle after clr is sampled.
  - In CLEAR: write ignored; rd_en_a/b ignored (valid stays 0); clr ignored (no restart).
- Reset asserted mid-sweep: immediate async return to IDLE, all registers 0, busy=0.
- Index arithmetic: counter is AW bits. Wrap from DEPTH-1 is never taken, because the FSM exits first.
- No X on outputs in any state; there is no default-X read path.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-first): a colliding read returns data_in on data_out_x the next cycle.
- Undefined (read-first): a colliding read returns the pre-write register value; the new value is visible from the following read.
- Applies to both ports independently. The write itself is unaffected in either mode.

Decomposition:
- Package regfile_mp_pkg:
  - state enum rf_state_e {RF_IDLE, RF_CLEAR}.
  - Default constants RF_WIDTH_DEF=16, RF_DEPTH_DEF=8.
- Sub-module regfile_rdport (parametrised WIDTH): read data register plus valid flop, with mux input and enable. Instantiated twice, for ports A and B.
- Storage array, write decode and clear FSM stay in regfile_mp.

Test Plan:
- Reset then read all: rst_n low 2 cycles, then read idx 0..7 on A -> data_out_a=0, valid_a one-cycle pulse each read.
- Write/read both ports: write 16'h00A5->R3 and 16'h1234->R6; next cycle read A=3, B=6 -> data_out_a=16'h00A5, data_out_b=16'h1234, both valid one cycle later.
- Collision: R2=16'h1111, then same cycle write 16'h2222->R2 and read A=2 -> 16'h2222 with REGFILE_BYPASS_EN, 16'h1111 without; a follow-up read returns 16'h2222 in both builds.
- Clear sweep:
  - Fill R0..R7 with 16'hFFFF; pulse clr together with write 16'h5555->R1.
  - Expect busy high exactly 8 cycles; reads and writes during busy give valid=0 and no update.
  - After busy falls, all registers read 0, including R1 (dropped write).
- Reset mid-sweep: assert rst_n=0 on the 4th busy cycle -> busy=0 immediately, FSM IDLE, all registers read 0 after release.
- Parametrisation: WIDTH=32, DEPTH=32; write 32'hDEADBEEF->R31, read B=31 -> 32'hDEADBEEF; clr gives busy for exactly 32 cycles.
